// File: rtl/wb_mem_responder.sv
// wb_mem_responder: pipelined Wishbone B4 target backed by a word-addressed RAM.
// Responses are in order, fixed LATENCY, at most MAX_OUTSTANDING in flight.
// Optional feature macro: WB_RESP_ERR_EN. When it is defined, addresses at or above
// MEM_WORDS*4 answer with err_o and never write the RAM. When it is undefined,
// addresses wrap and every request acks.
module wb_mem_responder #(
  parameter int    MEM_WORDS       = 4096,
  parameter int    LATENCY         = 2,
  parameter int    MAX_OUTSTANDING = 2,
  parameter string MEMORY_FILE     = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0]        mem [MEM_WORDS];
  logic [LATENCY-1:0] pipe_v;
  logic [LATENCY-1:0] pipe_e;
  logic [31:0]        pipe_d [LATENCY];
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic               accept;
  logic               resp;
  logic               oob;
  logic               unused_bits;

  assign idx     = addr_i[IDX_W+1:2];
  assign resp    = pipe_v[LATENCY-1];
  // Stall depends only on registered state, so there is no path from cyc_i/stb_i.
  assign stall_o = (cnt == CNT_MAX) & ~resp;
  assign accept  = cyc_i & stb_i & ~stall_o;

`ifdef WB_RESP_ERR_EN
  assign oob         = |addr_i[31:IDX_W+2];
  assign err_o       = pipe_v[LATENCY-1] & pipe_e[LATENCY-1];
  assign unused_bits = ^addr_i[1:0];
`else
  assign oob         = 1'b0;
  assign err_o       = 1'b0;
  assign unused_bits = ^{addr_i[31:IDX_W+2], addr_i[1:0], pipe_e[LATENCY-1]};
`endif

  assign ack_o  = pipe_v[LATENCY-1] & ~pipe_e[LATENCY-1];
  assign data_o = pipe_v[LATENCY-1] ? pipe_d[LATENCY-1] : 32'h0;

  // Clear the RAM at start of simulation.
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
  end

  // Byte-lane writes commit at the acceptance edge; out-of-range writes are dropped.
  always @(posedge clk) begin
    if (accept & we_i & ~oob) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_i[b]) mem[idx][8*b +: 8] <= data_i[8*b +: 8];
      end
    end
  end

  // Response shift register and outstanding counter; cyc_i low aborts everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      pipe_e <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_d[i] <= 32'h0;
      cnt    <= '0;
    end else if (!cyc_i) begin
      pipe_v <= '0;
      cnt    <= '0;
    end else begin
      pipe_v[0] <= accept;
      pipe_e[0] <= accept & oob;
      // Reads sample the RAM before this edge's write, writes and errors return zero.
      pipe_d[0] <= (accept & ~we_i & ~oob) ? mem[idx] : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      if (accept & ~resp)      cnt <= cnt + CNT_ONE;
      else if (~accept & resp) cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: u0 uses LATENCY=2/MAX=2, u1 uses LATENCY=3/MAX=2.
module tb_wb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc0, cyc1, stb, we;
  logic [3:0]  sel;
  logic [31:0] addr, wdata;
  logic [31:0] data0, data1;
  logic        ack0, err0, stall0;
  logic        ack1, err1, stall1;

  int checks   = 0;
  int failures = 0;

  // u1 monitor state
  logic        mon_en = 1'b0;
  logic [31:0] q1[$];
  int          acc1, first_stall, max_cnt1;

  always #5 clk = ~clk;

  wb_mem_responder #(.MEM_WORDS(4096), .LATENCY(2), .MAX_OUTSTANDING(2)) u0 (
    .clk(clk), .rst_n(rst_n), .cyc_i(cyc0), .stb_i(stb), .we_i(we), .sel_i(sel),
    .addr_i(addr), .data_i(wdata), .data_o(data0), .ack_o(ack0), .err_o(err0),
    .stall_o(stall0));

  wb_mem_responder #(.MEM_WORDS(256), .LATENCY(3), .MAX_OUTSTANDING(2)) u1 (
    .clk(clk), .rst_n(rst_n), .cyc_i(cyc1), .stb_i(stb), .we_i(we), .sel_i(sel),
    .addr_i(addr), .data_i(wdata), .data_o(data1), .ack_o(ack1), .err_o(err1),
    .stall_o(stall1));

  // Records u1 accepts, responses and outstanding depth, sampled mid-cycle.
  always @(negedge clk) begin
    if (!mon_en) begin
      q1.delete();
      acc1        = 0;
      first_stall = -1;
      max_cnt1    = 0;
    end else begin
      if (cyc1 && stb && !stall1) acc1++;
      if (ack1) q1.push_back(data1);
      if (stall1 && first_stall < 0) first_stall = acc1;
      if (int'(u1.cnt) > max_cnt1) max_cnt1 = int'(u1.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
  endtask

  task automatic idle();
    stb = 1'b0; we = 1'b0; sel = 4'h0; addr = 32'h0; wdata = 32'h0;
  endtask

  // Holds the current request on u1 until it is accepted at an edge.
  task automatic accept1();
    int n = 0;
    while (stall1 && n < 20) begin
      tick();
      n++;
    end
    chk("u1_accept_wait", {31'b0, stall1}, 32'h0);
    tick();
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 | 32'(i * 17 + 1);
  endfunction

  initial begin
    rst_n = 1'b0; cyc0 = 1'b0; cyc1 = 1'b0;
    idle();
    #12;
    chk("rst_ack0",   {31'b0, ack0},   32'h0);
    chk("rst_err0",   {31'b0, err0},   32'h0);
    chk("rst_stall0", {31'b0, stall0}, 32'h0);
    chk("rst_data0",  data0,           32'h0);
    chk("rst_ack1",   {31'b0, ack1},   32'h0);
    chk("rst_stall1", {31'b0, stall1}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Preload u0: word 4, word 8, word 0.
    cyc0 = 1'b1;
    drive(1'b1, 32'h10, 32'hDEADBEEF, 4'hF); tick();
    drive(1'b1, 32'h20, 32'hAABBCCDD, 4'hF); tick();
    chk("wr1_ack",        {31'b0, ack0},   32'h1);
    chk("wr1_data_zero",  data0,           32'h0);
    chk("full_resp_nostall", {31'b0, stall0}, 32'h0);
    drive(1'b1, 32'h00, 32'h01020304, 4'hF); tick();
    chk("wr2_ack", {31'b0, ack0}, 32'h1);
    idle(); tick();
    chk("wr3_ack", {31'b0, ack0}, 32'h1);
    tick();

    // Single read, LATENCY=2.
    drive(1'b0, 32'h10, 32'h0, 4'hF); tick();
    idle();
    chk("rd_not_early", {31'b0, ack0}, 32'h0);
    tick();
    chk("rd_ack",  {31'b0, ack0}, 32'h1);
    chk("rd_data", data0,         32'hDEADBEEF);
    tick();
    chk("rd_one_cycle",  {31'b0, ack0}, 32'h0);
    chk("rd_data_idle",  data0,         32'h0);

    // Byte-lane write then two back-to-back reads.
    drive(1'b1, 32'h20, 32'h11223344, 4'b0101); tick();
    drive(1'b0, 32'h20, 32'h0, 4'hF); tick();
    chk("bl_wr_ack",  {31'b0, ack0},   32'h1);
    chk("bl_nostall", {31'b0, stall0}, 32'h0);
    tick();
    idle();
    chk("bl_rd1_ack",  {31'b0, ack0}, 32'h1);
    chk("bl_rd1_data", data0,         32'hAA22CC44);
    tick();
    chk("bl_rd2_data", data0,         32'hAA22CC44);
    tick();

    // sel=0 write acks but changes nothing.
    drive(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0); tick();
    idle(); tick();
    chk("sel0_ack", {31'b0, ack0}, 32'h1);
    tick();
    drive(1'b0, 32'h10, 32'h0, 4'hF); tick();
    idle(); tick();
    chk("sel0_keep", data0, 32'hDEADBEEF);
    tick();

    // Abort: two reads, cyc drops while the first is at the last stage.
    drive(1'b0, 32'h10, 32'h0, 4'hF); tick();
    drive(1'b0, 32'h20, 32'h0, 4'hF); tick();
    cyc0 = 1'b0;
    idle();
    chk("abort_last_resp", data0, 32'hDEADBEEF);
    tick();
    chk("abort_drop1", {31'b0, ack0}, 32'h0);
    tick();
    chk("abort_drop2", {31'b0, ack0}, 32'h0);
    cyc0 = 1'b1;
    drive(1'b0, 32'h20, 32'h0, 4'hF);
    chk("abort_nostall", {31'b0, stall0}, 32'h0);
    tick();
    idle(); tick();
    chk("abort_new_ack",  {31'b0, ack0}, 32'h1);
    chk("abort_new_data", data0,         32'hAA22CC44);
    tick();

    // Address 0x4000 is one past the end of a 4096-word RAM.
    drive(1'b1, 32'h4000, 32'h5A5A5A5A, 4'hF); tick();
    idle(); tick();
`ifdef WB_RESP_ERR_EN
    chk("oob_err",   {31'b0, err0}, 32'h1);
    chk("oob_noack", {31'b0, ack0}, 32'h0);
    chk("oob_data",  data0,         32'h0);
`else
    chk("wrap_ack",   {31'b0, ack0}, 32'h1);
    chk("wrap_noerr", {31'b0, err0}, 32'h0);
`endif
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'hF); tick();
    idle(); tick();
    chk("w0_ack", {31'b0, ack0}, 32'h1);
`ifdef WB_RESP_ERR_EN
    chk("w0_unchanged", data0, 32'h01020304);
`else
    chk("w0_wrapped", data0, 32'h5A5A5A5A);
`endif
    tick();
    cyc0 = 1'b0;

    // Back-pressure on u1 (LATENCY=3, MAX=2).
    cyc1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), pat(i), 4'hF);
      accept1();
    end
    idle();
    repeat (6) tick();
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'hF);
      accept1();
    end
    idle();
    for (int n = 0; n < 20 && q1.size() < 6; n++) tick();
    repeat (3) tick();
    chk("bp_ack_count",   32'(q1.size()),    32'd6);
    chk("bp_accepts",     32'(acc1),         32'd6);
    chk("bp_first_stall", 32'(first_stall),  32'd2);
    chk("bp_max_cnt_le2", {31'b0, max_cnt1 <= 2}, 32'h1);
    chk("bp_noerr",       {31'b0, err1},     32'h0);
    for (int i = 0; i < 6; i++) chk($sformatf("bp_data%0d", i), q1[i], pat(i));
    mon_en = 1'b0;
    cyc1 = 1'b0;
    tick();

    // Async reset with two responses in flight on u0.
    cyc0 = 1'b1;
    drive(1'b0, 32'h10, 32'h0, 4'hF); tick();
    drive(1'b0, 32'h20, 32'h0, 4'hF); tick();
    idle();
    chk("prerst_ack", {31'b0, ack0}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack",   {31'b0, ack0},   32'h0);
    chk("arst_err",   {31'b0, err0},   32'h0);
    chk("arst_data",  data0,           32'h0);
    chk("arst_stall", {31'b0, stall0}, 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst_noack%0d", i), {31'b0, ack0}, 32'h0);
    end
    drive(1'b0, 32'h10, 32'h0, 4'hF); tick();
    idle(); tick();
    chk("rst_ram_kept", data0, 32'hDEADBEEF);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
